shift_register_sequencer: RTL and testbench
===========================================

// Module: shift_register_sequencer
// PURPOSE
//   Controller that sequences an internal parallel-load shift register into a serial stream.
//   Accepts a parallel word on a valid/ready handshake and loads it.
//   Shifts the word out one bit per bit-period, then pulses done.
//   Sits between a parallel producer and a serial line/consumer; one word in flight at a time.
// PARAMETERS
//   WIDTH      8   data word width in bits (>=2)
//   CLK_DIV    1   clk cycles per serial bit (>=1); 1 = one bit per clk
//   LSB_FIRST  0   0: MSB shifted first; 1: LSB shifted first
// PORTS
//   clk        in   1      rising-edge clock, sole clock domain
//   reset      in   1      synchronous, active-low reset (asserted when 0)
//   in_valid   in   1      producer has a word on in_data
//   in_ready   out  1      sequencer can accept a word (IDLE only)
//   in_data    in   WIDTH  parallel word, captured on in_valid & in_ready
//   hold       in   1      stall: freezes bit timing and shift register
//   ser_out    out  1      serial data bit, registered
//   ser_valid  out  1      high while ser_out carries a data (or parity) bit
//   busy       out  1      high in every state except IDLE
//   done       out  1      one-cycle pulse after the final bit period
// BEHAVIOUR
//   Reset (reset==0 at a clk edge):
//     state=IDLE; in_ready=1; ser_out=1 (idle level); ser_valid=0; busy=0; done=0.
//     Bit/divider counters and shift register are cleared.
//   FSM states: IDLE -> SHIFT -> [PARITY] -> DONE -> IDLE.
//   IDLE:
//     in_ready=1. Handshake at edge k captures in_data and enters SHIFT.
//     bit_cnt=0, div_cnt=0. First bit is on ser_out from cycle k+1.
//   SHIFT:
//     ser_valid=1. ser_out = shreg[WIDTH-1] (MSB-first) or shreg[0] (LSB-first).
//     div_cnt counts 0..CLK_DIV-1; each bit is held exactly CLK_DIV unstalled cycles.
//     At div_cnt==CLK_DIV-1 and hold==0: shift by one, bit_cnt++, div_cnt=0.
//     After bit WIDTH-1 completes: go to PARITY (if PARITY_EN defined), else DONE.
//   hold==1 in SHIFT/PARITY: div_cnt, bit_cnt, shreg and ser_out are frozen.
//     hold in IDLE or DONE has no effect.
//   DONE:
//     Lasts one cycle. done=1, ser_valid=0, ser_out=1, in_ready=0.
//     Next state is IDLE.
//   Latency (no hold): handshake edge k; data bits occupy cycles k+1..k+WIDTH*CLK_DIV.
//     done is high in cycle k+WIDTH*CLK_DIV+1; in_ready rises the cycle after done.
//   in_valid while busy: ignored, no capture. The producer must hold the word until in_ready.
//   Counter widths: bit_cnt = $clog2(WIDTH+1); div_cnt = $clog2(CLK_DIV)
//     (minimum 1 bit). No wrap beyond terminal counts.
//   Reset mid-operation: the word is aborted, no done pulse, outputs take reset values.
//   hold and the terminal count coincide: hold wins; the shift occurs on the first unstalled terminal cycle.
// CONFIGURATION
//   PARITY_EN defined:
//     After the data bits, PARITY state drives the even-parity bit (^word) for CLK_DIV cycles.
//     ser_valid=1 during PARITY, then DONE. Total serial length is WIDTH+1 bit periods.
//   PARITY_EN undefined: no PARITY state; SHIFT goes directly to DONE.
// TESTING
//   1. WIDTH=8, CLK_DIV=1, MSB-first, word 8'b10101010:
//      ser_out = 1,0,1,0,1,0,1,0 in cycles k+1..k+8; done=1 at k+9; in_ready=1 at k+10.
//   2. CLK_DIV=4, word 8'hC3: each bit held 4 cycles.
//      Stream 1,1,0,0,0,0,1,1; done at k+33.
//   3. hold=1 for 3 cycles mid-bit 2 of 8'hF0: bit 2 lasts 3 extra cycles; done delayed by exactly 3.
//   4. reset=0 during bit 5: next cycle busy=0, ser_out=1, in_ready=1; done never pulses.
//   5. in_valid=1 with new data while busy: ignored; the first word completes unaltered,
//      then the second word is captured when in_ready=1.
//   6. PARITY_EN, word 8'h07: 8 data bits, then parity bit 1; done at k+10.
//      Word 8'h03: parity bit 0.

Source files
------------

// File: rtl/shift_register_sequencer.sv
// rtl/shift_register_sequencer.sv - parallel-load shift register sequenced onto a serial line
// Optional trailing even-parity bit is enabled by defining PARITY_EN.
module shift_register_sequencer #(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 1,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             hold,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic             ser_out_q, ser_out_d;
`ifdef PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Rotating rather than shifting keeps every register bit live; only the head bit is ever observed.
  logic [WIDTH-1:0] shreg_next;
  logic             load_bit;
  logic             next_bit;

  always_comb begin
    shreg_next = (LSB_FIRST != 0) ? {shreg_q[0], shreg_q[WIDTH-1:1]}
                                  : {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
    load_bit   = (LSB_FIRST != 0) ? in_data[0] : in_data[WIDTH-1];
    next_bit   = (LSB_FIRST != 0) ? shreg_next[0] : shreg_next[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      ser_out_q <= 1'b1;
`ifdef PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      ser_out_q <= ser_out_d;
`ifdef PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    ser_out_d = ser_out_q;
`ifdef PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        ser_out_d = 1'b1;
        if (in_valid) begin
          state_d   = S_SHIFT;
          shreg_d   = in_data;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          ser_out_d = load_bit;
`ifdef PARITY_EN
          parity_d  = ^in_data;
`endif
        end
      end
      S_SHIFT: begin
        // hold freezes everything, including a terminal-count cycle
        if (!hold) begin
          if (div_cnt_q == LAST_DIV) begin
            div_cnt_d = '0;
            bit_cnt_d = bit_cnt_q + BW'(1);
            shreg_d   = shreg_next;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef PARITY_EN
              state_d   = S_PARITY;
              ser_out_d = parity_q;
`else
              state_d   = S_DONE;
              ser_out_d = 1'b1;
`endif
            end else begin
              ser_out_d = next_bit;
            end
          end else begin
            div_cnt_d = div_cnt_q + DW'(1);
          end
        end
      end
`ifdef PARITY_EN
      S_PARITY: begin
        if (!hold) begin
          if (div_cnt_q == LAST_DIV) begin
            div_cnt_d = '0;
            state_d   = S_DONE;
            ser_out_d = 1'b1;
          end else begin
            div_cnt_d = div_cnt_q + DW'(1);
          end
        end
      end
`endif
      S_DONE: begin
        state_d   = S_IDLE;
        ser_out_d = 1'b1;
      end
      default: begin
        state_d   = S_IDLE;
        ser_out_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    ser_valid = (state_q == S_SHIFT) || (state_q == S_PARITY);
    ser_out   = ser_out_q;
  end

endmodule

// File: tb/tb_shift_register_sequencer.sv
// tb/tb_shift_register_sequencer.sv - directed bench for shift_register_sequencer
// Set PARITY_EN to exercise the trailing parity bit.
module tb_shift_register_sequencer;

`ifdef PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic v1, h1, r1, so1, sv1, b1, dn1;
  logic v4, h4, r4, so4, sv4, b4, dn4;
  logic [7:0] d1, d4;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  shift_register_sequencer #(.WIDTH(8), .CLK_DIV(1), .LSB_FIRST(0)) dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_ready(r1), .in_data(d1), .hold(h1),
    .ser_out(so1), .ser_valid(sv1), .busy(b1), .done(dn1)
  );

  shift_register_sequencer #(.WIDTH(8), .CLK_DIV(4), .LSB_FIRST(1)) dut4 (
    .clk(clk), .reset(reset), .in_valid(v4), .in_ready(r4), .in_data(d4), .hold(h4),
    .ser_out(so4), .ser_valid(sv4), .busy(b4), .done(dn4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Starts at a negedge in an IDLE cycle; ends at the negedge of the cycle where in_ready returns.
  task automatic run_word(input bit sel, input logic [7:0] w, input int hold_at, input int hold_len,
                          input bit keep, input logic [7:0] nxt, input int exp_done);
    int div, total, b, cnt, c;
    bit held;
    logic eb;
    div   = sel ? 4 : 1;
    total = 8 + PB;
    check("ready_before_load", sel ? r4 : r1, 1);
    if (sel) begin v4 = 1'b1; d4 = w; end
    else     begin v1 = 1'b1; d1 = w; end
    @(negedge clk);
    if (sel) begin v4 = keep; d4 = keep ? nxt : w; end
    else     begin v1 = keep; d1 = keep ? nxt : w; end
    b = 0; cnt = 0; c = 1;
    while (b < total && c < 300) begin
      held = (c >= hold_at) && (c < hold_at + hold_len);
      if (sel) h4 = held; else h1 = held;
      if (b < 8) eb = sel ? w[b] : w[7-b];
      else       eb = ^w;
      check($sformatf("w%02h_bit%0d_cyc%0d", w, b, c), sel ? so4 : so1, eb);
      check($sformatf("w%02h_valid_cyc%0d", w, c), sel ? sv4 : sv1, 1);
      if (!held) begin
        cnt++;
        if (cnt == div) begin cnt = 0; b++; end
      end
      @(negedge clk);
      c++;
    end
    h1 = 1'b0; h4 = 1'b0;
    check($sformatf("w%02h_done_cycle", w), c, exp_done);
    check("done_pulse", sel ? dn4 : dn1, 1);
    check("ready_low_in_done", sel ? r4 : r1, 0);
    check("idle_level_in_done", sel ? so4 : so1, 1);
    check("valid_low_in_done", sel ? sv4 : sv1, 0);
    @(negedge clk);
    check("done_cleared", sel ? dn4 : dn1, 0);
    check("ready_back", sel ? r4 : r1, 1);
    check("busy_cleared", sel ? b4 : b1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit saw_done;
    reset = 1'b0;
    v1 = 0; h1 = 0; d1 = 8'h00;
    v4 = 0; h4 = 0; d4 = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready1", r1, 1);
    check("rst_busy1", b1, 0);
    check("rst_ser1", so1, 1);
    check("rst_valid1", sv1, 0);
    check("rst_done1", dn1, 0);
    check("rst_ready4", r4, 1);
    check("rst_ser4", so4, 1);
    reset = 1'b1;
    @(negedge clk);

    // MSB-first, one bit per clk
    run_word(1'b0, 8'b10101010, 0, 0, 1'b0, 8'h00, 9 + PB);
    // four clks per bit; C3 reads the same in either bit order
    run_word(1'b1, 8'hC3, 0, 0, 1'b0, 8'h00, 33 + 4 * PB);
    run_word(1'b1, 8'h01, 0, 0, 1'b0, 8'h00, 33 + 4 * PB);
    // 3-cycle stall during bit 2
    run_word(1'b0, 8'hF0, 3, 3, 1'b0, 8'h00, 12 + PB);
    // stall starting on the terminal cycle of bit 2
    run_word(1'b1, 8'h5A, 12, 2, 1'b0, 8'h00, 35 + 4 * PB);

    // abort by reset during bit 5
    check("abort_ready_pre", r1, 1);
    v1 = 1'b1; d1 = 8'hA5;
    @(negedge clk);
    v1 = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_bit5", so1, 1);
    check("abort_busy_pre", b1, 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_busy", b1, 0);
    check("abort_ser", so1, 1);
    check("abort_ready", r1, 1);
    check("abort_valid", sv1, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (dn1 === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    check("abort_no_done", saw_done, 0);

    // second word offered while busy is held off until in_ready
    run_word(1'b0, 8'h96, 0, 0, 1'b1, 8'h3C, 9 + PB);
    run_word(1'b0, 8'h3C, 0, 0, 1'b0, 8'h00, 9 + PB);

`ifdef PARITY_EN
    run_word(1'b0, 8'h07, 0, 0, 1'b0, 8'h00, 10);
    run_word(1'b0, 8'h03, 0, 0, 1'b0, 8'h00, 10);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
